// File: rtl/jtopl_pkg.sv
// Shared constants and types for the OPL CPU-side write decoder.
package jtopl_pkg;

    // Operator register bases (slot offset 0x00-0x15 added)
    localparam logic [7:0] OP_MULT  = 8'h20;
    localparam logic [7:0] OP_KSLTL = 8'h40;
    localparam logic [7:0] OP_ARDR  = 8'h60;
    localparam logic [7:0] OP_SLRR  = 8'h80;
    localparam logic [7:0] OP_WAV   = 8'hE0;

    // Channel register bases (channel 0-8 added)
    localparam logic [7:0] CH_FNLO  = 8'hA0;
    localparam logic [7:0] CH_FNHI  = 8'hB0;
    localparam logic [7:0] CH_FBCON = 8'hC0;

    // Global registers
    localparam logic [7:0] G_RHY  = 8'hBD;
    localparam logic [7:0] G_TEST = 8'h01;
    localparam logic [7:0] G_TA   = 8'h02;
    localparam logic [7:0] G_TB   = 8'h03;
    localparam logic [7:0] G_TCTL = 8'h04;
    localparam logic [7:0] G_CSM  = 8'h08;

    // Number of operator slots in one round; an update is held this many cen pulses
    localparam int HOLD_SLOTS = 18;

    // Index of the update strobe; bit position in the internal strobe vector
    typedef enum logic [2:0] {
        UP_MULT  = 3'd0,
        UP_KSLTL = 3'd1,
        UP_ARDR  = 3'd2,
        UP_SLRR  = 3'd3,
        UP_WAV   = 3'd4,
        UP_FNLO  = 3'd5,
        UP_FNHI  = 3'd6,
        UP_FBCON = 3'd7
    } up_sel_e;

    // Address decode result: hit = address lies in a register-file range,
    // valid = the slot/channel inside that range exists
    typedef struct packed {
        logic    hit;
        logic    valid;
        up_sel_e up;
        logic [1:0] group;
        logic [2:0] sub;
    } dec_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } hold_state_e;

    // Channel number to group (ch/3)
    function automatic logic [1:0] ch_group(input logic [3:0] ch);
        logic [1:0] g;
        if (ch >= 4'd6)      g = 2'd2;
        else if (ch >= 4'd3) g = 2'd1;
        else                 g = 2'd0;
        return g;
    endfunction

    // Channel number to subslot (ch%3)
    function automatic logic [2:0] ch_sub(input logic [3:0] ch);
        logic [2:0] s;
        case (ch)
            4'd1, 4'd4, 4'd7: s = 3'd1;
            4'd2, 4'd5, 4'd8: s = 3'd2;
            default:          s = 3'd0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/jtopl_wrdec_if.sv
// CPU bus of the OPL: chip select, write strobe, port select and data.
interface jtopl_wrdec_if;
    logic       cs_n;
    logic       wr_n;
    logic       addr;
    logic [7:0] din;

    modport master (output cs_n, wr_n, addr, din);
    modport slave  (input  cs_n, wr_n, addr, din);
endinterface

// File: rtl/jtopl_wrdec_map.sv
// Combinational map from a latched register address to strobe/slot selection.
module jtopl_wrdec_map
    import jtopl_pkg::*;
#(
    parameter int OPL_TYPE = 1
) (
    input  logic [7:0] addr,
    output dec_t       dec
);

    logic [4:0] off;
    logic [3:0] ch;
    logic       op_range;
    logic       ch_range;
    up_sel_e    op_up;
    up_sel_e    ch_up;

    assign off = addr[4:0];
    assign ch  = addr[3:0];

    // Operator band: upper three address bits select the parameter
    always_comb begin
        op_range = 1'b1;
        op_up    = UP_MULT;
        case (addr[7:5])
            OP_MULT[7:5]:  op_up = UP_MULT;
            OP_KSLTL[7:5]: op_up = UP_KSLTL;
            OP_ARDR[7:5]:  op_up = UP_ARDR;
            OP_SLRR[7:5]:  op_up = UP_SLRR;
            OP_WAV[7:5]: begin
                op_up    = UP_WAV;
                // plain OPL has no waveform registers at all
                op_range = (OPL_TYPE == 2);
            end
            default:       op_range = 1'b0;
        endcase
    end

    // Channel band: upper nibble selects the parameter; 0xBD is a global
    always_comb begin
        ch_range = 1'b1;
        ch_up    = UP_FNLO;
        case (addr[7:4])
            CH_FNLO[7:4]:  ch_up = UP_FNLO;
            CH_FNHI[7:4]:  begin
                ch_up    = UP_FNHI;
                ch_range = (addr != G_RHY);
            end
            CH_FBCON[7:4]: ch_up = UP_FBCON;
            default:       ch_range = 1'b0;
        endcase
    end

    // Merge both bands; offsets 6/7 within a group and group 3 do not exist
    always_comb begin
        dec = '0;
        if (op_range) begin
            dec.hit   = 1'b1;
            dec.valid = (off[4:3] != 2'b11) && (off[2:1] != 2'b11);
            dec.up    = op_up;
            dec.group = off[4:3];
            dec.sub   = off[2:0];
        end else if (ch_range) begin
            dec.hit   = 1'b1;
            dec.valid = (ch <= 4'd8);
            dec.up    = ch_up;
            dec.group = ch_group(ch);
            dec.sub   = ch_sub(ch);
        end
    end

endmodule

// File: rtl/jtopl_wrdec.sv
// OPL CPU write decoder: bus edge detect, address latch, held register-file
// updates for one full slot round, and the global control registers.
module jtopl_wrdec
    import jtopl_pkg::*;
#(
    parameter int OPL_TYPE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cen,
    jtopl_wrdec_if.slave      bus,
    output logic              write,
    output logic [7:0]        regdin,
    output logic [1:0]        sel_group,
    output logic [2:0]        sel_sub,
    output logic              up_mult,
    output logic              up_ksl_tl,
    output logic              up_ar_dr,
    output logic              up_sl_rr,
    output logic              up_wav,
    output logic              up_fnumlo,
    output logic              up_fnumhi,
    output logic              up_fbcon,
    output logic              busy,
    output logic              wave_mode,
    output logic              csm,
    output logic              note_sel,
    output logic [7:0]        value_A,
    output logic [7:0]        value_B,
    output logic              load_A,
    output logic              load_B,
    output logic              flagen_A,
    output logic              flagen_B,
    output logic              clr_flag,
    output logic              am_dep,
    output logic              vib_dep,
    output logic              rhy_en,
    output logic [4:0]        rhy_kon
);

    // ---------------- input stage ----------------
    logic       req;
    logic       idle_reg;      // req seen low on the previous clk
    logic       ev_reg;
    logic       ev_addr_reg;
    logic [7:0] ev_din_reg;
    logic [7:0] addr_reg;

    assign req = ~bus.cs_n & ~bus.wr_n;

    // Register the bus and flag a new access; idle_reg resets low so a
    // request already active at reset release is not taken as an event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_reg    <= 1'b0;
            ev_reg      <= 1'b0;
            ev_addr_reg <= 1'b0;
            ev_din_reg  <= 8'd0;
        end else begin
            idle_reg    <= ~req;
            ev_reg      <= req & idle_reg;
            ev_addr_reg <= bus.addr;
            ev_din_reg  <= bus.din;
        end
    end

    logic data_ev;
    logic addr_ev;

    assign data_ev = ev_reg &  ev_addr_reg;
    assign addr_ev = ev_reg & ~ev_addr_reg;

    // Address port write latches the register number
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) addr_reg <= 8'd0;
        else if (addr_ev) addr_reg <= ev_din_reg;
    end

    // ---------------- decode ----------------
    dec_t       dec;
    logic [7:0] up_onehot;

    jtopl_wrdec_map #(
        .OPL_TYPE (OPL_TYPE)
    ) u_map (
        .addr (addr_reg),
        .dec  (dec)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_onehot
            assign up_onehot[gi] = (dec.up == up_sel_e'(3'(gi)));
        end
    endgenerate

    // ---------------- update hold FSM ----------------
    hold_state_e state_reg, state_next;
    logic [4:0]  cnt_reg, cnt_next;
    logic [7:0]  up_reg, up_next;
    logic        load;
    logic        write_reg;
    logic [7:0]  regdin_reg;
    logic [1:0]  group_reg;
    logic [2:0]  sub_reg;

    // Next hold state: a valid write (re)starts the round, an invalid
    // register-file address cancels it, otherwise count slots down
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        up_next    = up_reg;
        load       = 1'b0;
        if (data_ev && dec.valid) begin
            load       = 1'b1;
            state_next = ST_HOLD;
            cnt_next   = 5'(HOLD_SLOTS);
            up_next    = up_onehot;
        end else if (data_ev && dec.hit) begin
            state_next = ST_IDLE;
            cnt_next   = 5'd0;
            up_next    = 8'd0;
        end else if (state_reg == ST_HOLD && cen) begin
            if (cnt_reg == 5'd1) begin
                state_next = ST_IDLE;
                cnt_next   = 5'd0;
                up_next    = 8'd0;
            end else begin
                cnt_next = cnt_reg - 5'd1;
            end
        end
    end

    // Hold state, strobes and the data/selection held for the register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= 5'd0;
            up_reg     <= 8'd0;
            write_reg  <= 1'b0;
            regdin_reg <= 8'd0;
            group_reg  <= 2'd0;
            sub_reg    <= 3'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            up_reg    <= up_next;
            write_reg <= load;
            if (load) begin
                regdin_reg <= ev_din_reg;
                group_reg  <= dec.group;
                sub_reg    <= dec.sub;
            end
        end
    end

    // ---------------- global registers ----------------
    logic       wave_mode_reg, csm_reg, note_sel_reg;
    logic [7:0] value_a_reg, value_b_reg;
    logic       load_a_reg, load_b_reg, flagen_a_reg, flagen_b_reg;
    logic       clr_flag_reg;
    logic       am_dep_reg, vib_dep_reg, rhy_en_reg;
    logic [4:0] rhy_kon_reg;

    // Global registers update directly on the data event; a 0x04 write with
    // bit7 only resets the flags and leaves the timer controls untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wave_mode_reg <= 1'b0;
            csm_reg       <= 1'b0;
            note_sel_reg  <= 1'b0;
            value_a_reg   <= 8'd0;
            value_b_reg   <= 8'd0;
            load_a_reg    <= 1'b0;
            load_b_reg    <= 1'b0;
            flagen_a_reg  <= 1'b0;
            flagen_b_reg  <= 1'b0;
            clr_flag_reg  <= 1'b0;
            am_dep_reg    <= 1'b0;
            vib_dep_reg   <= 1'b0;
            rhy_en_reg    <= 1'b0;
            rhy_kon_reg   <= 5'd0;
        end else begin
            clr_flag_reg <= 1'b0;
            if (data_ev) begin
                case (addr_reg)
                    G_TEST: if (OPL_TYPE == 2) wave_mode_reg <= ev_din_reg[5];
                    G_TA:   value_a_reg <= ev_din_reg;
                    G_TB:   value_b_reg <= ev_din_reg;
                    G_TCTL: begin
                        if (ev_din_reg[7]) begin
                            clr_flag_reg <= 1'b1;
                        end else begin
                            load_a_reg   <= ev_din_reg[0];
                            load_b_reg   <= ev_din_reg[1];
                            flagen_a_reg <= ~ev_din_reg[6];
                            flagen_b_reg <= ~ev_din_reg[5];
                        end
                    end
                    G_CSM: begin
                        csm_reg      <= ev_din_reg[7];
                        note_sel_reg <= ev_din_reg[6];
                    end
                    G_RHY: begin
                        am_dep_reg  <= ev_din_reg[7];
                        vib_dep_reg <= ev_din_reg[6];
                        rhy_en_reg  <= ev_din_reg[5];
                        rhy_kon_reg <= ev_din_reg[4:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- outputs ----------------
    assign write     = write_reg;
    assign regdin    = regdin_reg;
    assign sel_group = group_reg;
    assign sel_sub   = sub_reg;
    assign busy      = (state_reg == ST_HOLD);

    assign up_mult   = up_reg[UP_MULT];
    assign up_ksl_tl = up_reg[UP_KSLTL];
    assign up_ar_dr  = up_reg[UP_ARDR];
    assign up_sl_rr  = up_reg[UP_SLRR];
    assign up_wav    = up_reg[UP_WAV];
    assign up_fnumlo = up_reg[UP_FNLO];
    assign up_fnumhi = up_reg[UP_FNHI];
    assign up_fbcon  = up_reg[UP_FBCON];

    assign wave_mode = wave_mode_reg;
    assign csm       = csm_reg;
    assign note_sel  = note_sel_reg;
    assign value_A   = value_a_reg;
    assign value_B   = value_b_reg;
    assign load_A    = load_a_reg;
    assign load_B    = load_b_reg;
    assign flagen_A  = flagen_a_reg;
    assign flagen_B  = flagen_b_reg;
    assign clr_flag  = clr_flag_reg;
    assign am_dep    = am_dep_reg;
    assign vib_dep   = vib_dep_reg;
    assign rhy_en    = rhy_en_reg;
    assign rhy_kon   = rhy_kon_reg;

endmodule

// File: tb/tb_jtopl_wrdec.sv
// Scoreboard bench for jtopl_wrdec: stimulus pushes expected write/clr_flag
// events, a monitor pops them when the DUT pulses write or clr_flag and
// checks that every hold lasts 18 cen pulses.
module tb_jtopl_wrdec;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic cen   = 1'b0;

    jtopl_wrdec_if bus ();

    // OPL2 instance outputs
    logic       write, busy, clr_flag;
    logic [7:0] regdin, value_A, value_B;
    logic [1:0] sel_group;
    logic [2:0] sel_sub;
    logic       up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav, up_fnumlo, up_fnumhi, up_fbcon;
    logic       wave_mode, csm, note_sel, load_A, load_B, flagen_A, flagen_B;
    logic       am_dep, vib_dep, rhy_en;
    logic [4:0] rhy_kon;

    // OPL instance outputs
    logic       t1_write, t1_busy, t1_clr_flag;
    logic [7:0] t1_regdin, t1_value_A, t1_value_B;
    logic [1:0] t1_sel_group;
    logic [2:0] t1_sel_sub;
    logic       t1_up_mult, t1_up_ksl_tl, t1_up_ar_dr, t1_up_sl_rr, t1_up_wav, t1_up_fnumlo, t1_up_fnumhi, t1_up_fbcon;
    logic       t1_wave_mode, t1_csm, t1_note_sel, t1_load_A, t1_load_B, t1_flagen_A, t1_flagen_B;
    logic       t1_am_dep, t1_vib_dep, t1_rhy_en;
    logic [4:0] t1_rhy_kon;

    jtopl_wrdec #(.OPL_TYPE(2)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .bus(bus),
        .write(write), .regdin(regdin), .sel_group(sel_group), .sel_sub(sel_sub),
        .up_mult(up_mult), .up_ksl_tl(up_ksl_tl), .up_ar_dr(up_ar_dr), .up_sl_rr(up_sl_rr),
        .up_wav(up_wav), .up_fnumlo(up_fnumlo), .up_fnumhi(up_fnumhi), .up_fbcon(up_fbcon),
        .busy(busy), .wave_mode(wave_mode), .csm(csm), .note_sel(note_sel),
        .value_A(value_A), .value_B(value_B), .load_A(load_A), .load_B(load_B),
        .flagen_A(flagen_A), .flagen_B(flagen_B), .clr_flag(clr_flag),
        .am_dep(am_dep), .vib_dep(vib_dep), .rhy_en(rhy_en), .rhy_kon(rhy_kon)
    );

    jtopl_wrdec #(.OPL_TYPE(1)) dut_opl (
        .clk(clk), .rst_n(rst_n), .cen(cen), .bus(bus),
        .write(t1_write), .regdin(t1_regdin), .sel_group(t1_sel_group), .sel_sub(t1_sel_sub),
        .up_mult(t1_up_mult), .up_ksl_tl(t1_up_ksl_tl), .up_ar_dr(t1_up_ar_dr), .up_sl_rr(t1_up_sl_rr),
        .up_wav(t1_up_wav), .up_fnumlo(t1_up_fnumlo), .up_fnumhi(t1_up_fnumhi), .up_fbcon(t1_up_fbcon),
        .busy(t1_busy), .wave_mode(t1_wave_mode), .csm(t1_csm), .note_sel(t1_note_sel),
        .value_A(t1_value_A), .value_B(t1_value_B), .load_A(t1_load_A), .load_B(t1_load_B),
        .flagen_A(t1_flagen_A), .flagen_B(t1_flagen_B), .clr_flag(t1_clr_flag),
        .am_dep(t1_am_dep), .vib_dep(t1_vib_dep), .rhy_en(t1_rhy_en), .rhy_kon(t1_rhy_kon)
    );

    always #5 clk = ~clk;

    // Expected output events: kind 0 = write pulse, 1 = clr_flag pulse.
    // up bit order: {fbcon, fnumhi, fnumlo, wav, sl_rr, ar_dr, ksl_tl, mult}
    typedef struct packed {
        logic       kind;
        logic [7:0] up;
        logic [1:0] grp;
        logic [2:0] sub;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cen_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    function automatic logic [54:0] all_outs();
        return {write, regdin, sel_group, sel_sub,
                up_fbcon, up_fnumhi, up_fnumlo, up_wav, up_sl_rr, up_ar_dr, up_ksl_tl, up_mult,
                busy, wave_mode, csm, note_sel, value_A, value_B,
                load_A, load_B, flagen_A, flagen_B, clr_flag, am_dep, vib_dep, rhy_en, rhy_kon};
    endfunction

    // cen: one clk in three
    initial begin
        int div = 0;
        forever begin
            @(negedge clk);
            div++;
            cen = (div % 3 == 0);
        end
    end

    // Monitor: pops expected events on output pulses, counts cen during holds
    initial begin
        logic       cen_s;
        logic       busy_prev;
        logic       write_prev;
        logic       clr_prev;
        logic [7:0] act_up;
        exp_t       e;
        busy_prev  = 1'b0;
        write_prev = 1'b0;
        clr_prev   = 1'b0;
        forever begin
            @(posedge clk);
            cen_s = cen;
            #1;
            if (!rst_n) begin
                busy_prev  = 1'b0;
                write_prev = 1'b0;
                clr_prev   = 1'b0;
                cen_cnt    = 0;
            end else begin
                act_up = {up_fbcon, up_fnumhi, up_fnumlo, up_wav, up_sl_rr, up_ar_dr, up_ksl_tl, up_mult};
                if (write_prev) check("write_width", 64'(write), 64'd0);
                if (clr_prev)   check("clr_width", 64'(clr_flag), 64'd0);
                if (write && !write_prev) begin
                    if (exp_q.size() == 0 || exp_q[0].kind != 1'b0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got regdin 0x%0h up 0x%0h, required no write", regdin, act_up);
                    end else begin
                        e = exp_q.pop_front();
                        check("write_up", 64'(act_up), 64'(e.up));
                        check("write_sel", 64'({sel_group, sel_sub}), 64'({e.grp, e.sub}));
                        check("write_regdin", 64'(regdin), 64'(e.data));
                        check("write_busy", 64'(busy), 64'd1);
                    end
                    cen_cnt = 0;
                end else if (cen_s) begin
                    cen_cnt++;
                end
                if (clr_flag && !clr_prev) begin
                    if (exp_q.size() == 0 || exp_q[0].kind != 1'b1) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_clr_flag: got 1, required 0");
                    end else begin
                        e = exp_q.pop_front();
                        check("clr_flag_pulse", 64'(clr_flag), 64'd1);
                    end
                end
                if (busy_prev && !busy && !write)
                    check("hold_cens", 64'(cen_cnt), 64'd18);
                busy_prev  = busy;
                write_prev = write;
                clr_prev   = clr_flag;
            end
        end
    end

    task automatic bus_wr(input logic a, input logic [7:0] d, input int hold);
        @(negedge clk);
        bus.cs_n = 1'b0;
        bus.wr_n = 1'b0;
        bus.addr = a;
        bus.din  = d;
        repeat (hold) @(negedge clk);
        bus.cs_n = 1'b1;
        bus.wr_n = 1'b1;
    endtask

    task automatic reg_wr(input logic [7:0] a, input logic [7:0] d, input int hold = 1);
        bus_wr(1'b0, a, 1);
        bus_wr(1'b1, d, hold);
        $display("bus write reg 0x%02h <= 0x%02h", a, d);
    endtask

    task automatic push_wr(input logic [7:0] up, input logic [1:0] g, input logic [2:0] s, input logic [7:0] d);
        exp_t e;
        e.kind = 1'b0; e.up = up; e.grp = g; e.sub = s; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_clr();
        exp_t e;
        e = '0;
        e.kind = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        repeat (2) @(negedge clk);
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got busy 1 after 400 clk, required 0", name);
        end
        settle();
    endtask

    initial begin
        int n;
        bus.cs_n = 1'b1;
        bus.wr_n = 1'b1;
        bus.addr = 1'b0;
        bus.din  = 8'd0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'(all_outs()), 64'd0);
        rst_n = 1'b1;
        settle();

        // Operator KSL/TL, slot 3 of group 0
        push_wr(8'h02, 2'd0, 3'd3, 8'h3F);
        reg_wr(8'h43, 8'h3F);
        wait_idle("ksltl");

        // Channel 7 fnum high; channel 9 does not exist
        push_wr(8'h40, 2'd2, 3'd1, 8'h2A);
        reg_wr(8'hB7, 8'h2A);
        wait_idle("fnumhi");
        reg_wr(8'hA9, 8'h55);
        settle();
        check("ch9_busy", 64'(busy), 64'd0);
        check("ch9_strobes", 64'({up_fbcon, up_fnumhi, up_fnumlo, up_wav, up_sl_rr, up_ar_dr, up_ksl_tl, up_mult}), 64'd0);

        // Offset 6 invalid; offset 0x15 is group 2 slot 5
        reg_wr(8'h26, 8'h01);
        settle();
        check("off6_busy", 64'(busy), 64'd0);
        check("off6_mult", 64'(up_mult), 64'd0);
        push_wr(8'h01, 2'd2, 3'd5, 8'h77);
        reg_wr(8'h35, 8'h77);
        wait_idle("off15");

        // Waveform select: OPL2 takes it, OPL ignores it
        push_wr(8'h10, 2'd0, 3'd0, 8'h03);
        reg_wr(8'hE0, 8'h03);
        repeat (2) @(negedge clk);
        check("opl2_up_wav", 64'(up_wav), 64'd1);
        check("opl_up_wav", 64'(t1_up_wav), 64'd0);
        check("opl_busy", 64'(t1_busy), 64'd0);
        wait_idle("wav");
        reg_wr(8'h01, 8'h20);
        settle();
        check("opl2_wave_mode", 64'(wave_mode), 64'd1);
        check("opl_wave_mode", 64'(t1_wave_mode), 64'd0);

        // Long wr_n low gives one event; replace the update mid-hold
        push_wr(8'h01, 2'd0, 3'd0, 8'h11);
        reg_wr(8'h20, 8'h11, 4);
        n = 0;
        while ((!busy || cen_cnt < 5) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL cen5_timeout: got cen_cnt %0d, required 5", cen_cnt);
        end
        push_wr(8'h04, 2'd0, 3'd0, 8'hF0);
        reg_wr(8'h60, 8'hF0);
        wait_idle("replace");

        // Timer control and flag reset
        reg_wr(8'h04, 8'h00);
        settle();
        check("tctl_00", 64'({load_A, load_B, flagen_A, flagen_B}), 64'b0011);
        push_clr();
        reg_wr(8'h04, 8'h80);
        settle();
        check("tctl_80_kept", 64'({load_A, load_B, flagen_A, flagen_B}), 64'b0011);
        reg_wr(8'h04, 8'h63);
        settle();
        check("tctl_63", 64'({load_A, load_B, flagen_A, flagen_B}), 64'b1100);

        // Timer presets, CSM/NOTE-SEL, rhythm
        reg_wr(8'h02, 8'hA5);
        reg_wr(8'h03, 8'h5A);
        reg_wr(8'h08, 8'hC0);
        reg_wr(8'hBD, 8'h3F);
        settle();
        check("value_A", 64'(value_A), 64'hA5);
        check("value_B", 64'(value_B), 64'h5A);
        check("csm_notesel", 64'({csm, note_sel}), 64'b11);
        check("rhythm", 64'({am_dep, vib_dep, rhy_en, rhy_kon}), 64'h3F);
        check("rhythm_no_busy", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of a hold
        push_wr(8'h02, 2'd0, 3'd1, 8'h12);
        reg_wr(8'h41, 8'h12);
        repeat (10) @(negedge clk);
        check("hold_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1 check("async_reset", 64'(all_outs()), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_wr(8'h08, 2'd0, 3'd0, 8'h0F);
        reg_wr(8'h80, 8'h0F);
        wait_idle("post_reset");

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtopl_wrdec.md
# jtopl_wrdec

CPU-side write decoder for the OPL core. Turns the two-port bus (address/data) into the per-register update strobes, slot selectors and held data byte that the operator/channel register file consumes. Holds each update for one full 18-slot round so the register file can capture it when the slot counter reaches the addressed slot. Also owns the global registers: test/wave enable, timers, CSM/NOTE-SEL and rhythm.

## Interface
- OPL_TYPE, 1, 1 = OPL (waveform select ignored); 2 = OPL2 (0x01 bit5 and 0xE0–0xF5 active)
- rst_n  in  1  asynchronous active-low reset
- clk  in  1  system clock
- cen  in  1  slot clock enable (one per operator slot)
- cs_n, wr_n  in  1 each  bus chip select / write strobe, sampled on clk
- addr  in  1  0 = register address port, 1 = data port
- din  in  8  bus data
- write  out  1  one-clk pulse on each accepted data write
- regdin  out  8  held data byte for the register file
- sel_group  out  2  target group
- sel_sub  out  3  target subslot
- up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav, up_fnumlo, up_fnumhi, up_fbcon  out  1 each  update strobes, one-hot or all zero
- busy  out  1  update hold in progress
- wave_mode, csm, note_sel  out  1 each  0x01 bit5, 0x08 bit7, 0x08 bit6
- value_A  out  8, value_B  out  8  timer presets (0x02, 0x03)
- load_A, load_B, flagen_A, flagen_B  out  1 each  0x04 bits 0, 1, !6, !5
- clr_flag  out  1  one-clk pulse when 0x04 is written with bit7=1; the other 0x04 bits are not updated on that write
- am_dep, vib_dep, rhy_en  out  1 each  0xBD bits 7, 6, 5
- rhy_kon  out  5  0xBD bits 4:0 (BD, SD, TOM, TC, HH)

## Operation
- Bus event: req = !cs_n & !wr_n, registered once; an event fires on the clk where req is high and its registered copy is low. Holding wr_n low produces one event only.
- addr=0 event: latch din into the 8-bit address register. No other effect.
- addr=1 event: decode the latched address together with din.
- Operator ranges 0x20/0x40/0x60/0x80/0xE0 + off, off = 0x00–0x15:
  - sel_group = off[4:3], sel_sub = off[2:0].
  - off[2:0] ∈ {6,7} or off[4:3] = 3 is invalid: no strobe.
- Channel ranges 0xA0/0xB0/0xC0 + ch, ch = 0–8:
  - sel_group = ch/3, sel_sub = ch%3.
  - ch > 8 is invalid.
- Valid decode: set exactly one up_* strobe, load regdin = din, pulse write, load the hold counter with 18, raise busy.
- Hold: each cen decrements the counter. The clk on which the 18th cen lands clears all up_* and busy. sel_* and regdin stay stable for the whole hold and keep their value after it.
- Data write while busy: the new decode replaces the old one in the same clk and the counter restarts at 18. An invalid address while busy clears the strobes and busy.
- Globals (0x01, 0x02, 0x03, 0x04, 0x08, 0xBD): update the global register on the event clk. No strobe, no busy.
- Unlisted addresses are ignored.
- OPL_TYPE=1: up_wav is never set and wave_mode is forced to 0.
- Reset: every output and internal register is 0, including address latch, counter, regdin and sel_*.

## Timing
- Event-to-output latency is 2 clk: 1 clk for the input register, 1 clk for the output register.
- write and clr_flag are exactly 1 clk wide.
- up_* rises in the same clk as write.
- up_* and busy are held for exactly 18 cen pulses after the event. cen coinciding with the event clk is not counted.
- rst_n assertion mid-hold drops all outputs immediately (asynchronous). After release, the first event needs req to be seen low for one clk.

## Structure
- Shared package jtopl_pkg holds the register base-address constants (OP_MULT=0x20, OP_KSLTL=0x40, OP_ARDR=0x60, OP_SLRR=0x80, OP_WAV=0xE0, CH_FNLO=0xA0, CH_FNHI=0xB0, CH_FBCON=0xC0, G_RHY=0xBD, G_TEST=0x01, G_TA=0x02, G_TB=0x03, G_TCTL=0x04, G_CSM=0x08) and HOLD_SLOTS=18.
- One combinational sub-module, jtopl_wrdec_map: address → {valid, strobe index, sel_group, sel_sub}.

## Test plan
- Addr 0x43, data 0x3F → up_ksl_tl=1, sel_group=0, sel_sub=3, regdin=0x3F, write 1 clk; busy falls on the 18th cen.
- Addr 0xB7, data 0x2A → up_fnumhi=1, sel_group=2, sel_sub=1; addr 0xA9, data 0x55 → no strobe, busy stays 0.
- Addr 0x26, data 0x01 (invalid slot) → no strobe. Addr 0x35 → sel_group=2, sel_sub=5. With OPL_TYPE=1, addr 0xE0 → no up_wav.
- Addr 0x20, data 0x11; at cen 5 write addr 0x60, data 0xF0 → up_mult drops and up_ar_dr rises in the same clk; counter restarts and busy lasts 18 more cen.
- Addr 0x04, data 0x80 → clr_flag 1 clk, load_A stays 0. Then addr 0x04, data 0x63 → load_A=1, load_B=1, flagen_A=0, flagen_B=0.
- Addr 0xBD, data 0x3F → rhy_en=1, rhy_kon=0x1F. Assert rst_n low during a hold → all outputs 0 immediately.
